// File: rtl/pipe_scoreboard.sv
// In-order register scoreboard: tracks destinations of in-flight instructions in a
// circular queue, flags RAW hazards on decode sources and stalls issue when needed.
module pipe_scoreboard #(
    parameter int REG_AW    = 5,
    parameter int DEPTH     = 4,
    parameter int SRC_PORTS = 2,
    parameter int BYPASS_WB = 1,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic                        issue_we,
    input  logic [REG_AW-1:0]           issue_dest,
    input  logic [SRC_PORTS-1:0]        src_valid,
    input  logic [SRC_PORTS*REG_AW-1:0] src_addr,
    input  logic                        retire_valid,
    input  logic                        flush,
    input  logic                        clear_err,
    output logic                        stall,
    output logic [SRC_PORTS-1:0]        src_hazard,
    output logic                        full,
    output logic                        empty,
    output logic [CW-1:0]               count,
    output logic                        err_overflow,
    output logic                        err_underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
    logic [DEPTH-1:0]  ent_we_q;
    logic [REG_AW-1:0] ent_dest_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_udf_q, err_udf_d;
    logic              push, pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_udf_q;

    // Per-port RAW match against every live writing entry; the oldest entry is
    // skipped while it retires if write-back bypass is enabled.
    always_comb begin
        src_hazard = '0;
        for (int i = 0; i < SRC_PORTS; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (src_valid[i] && (src_addr[i*REG_AW +: REG_AW] != '0) &&
                    ent_valid_q[j] && ent_we_q[j] &&
                    (ent_dest_q[j] == src_addr[i*REG_AW +: REG_AW]) &&
                    !((BYPASS_WB != 0) && retire_valid && (PW'(j) == rd_ptr_q))) begin
                    src_hazard[i] = 1'b1;
                end
            end
        end
    end

    assign stall = (|src_hazard) | (full & ~retire_valid);
    assign push  = issue_valid & ~stall & ~flush;
    assign pop   = retire_valid & ~empty & ~flush;

    // Next-state for queue bookkeeping; flush overrides everything.
    always_comb begin
        ent_valid_d = ent_valid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        // Pop clears before push sets, so a full queue can reuse the retiring slot.
        if (pop) begin
            ent_valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d              = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            ent_valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (flush) begin
            ent_valid_d = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
        end
    end

    // Sticky error flags; a set condition beats clear_err in the same cycle.
    always_comb begin
        err_ovf_d = (issue_valid & full & ~retire_valid & ~flush) | (err_ovf_q & ~clear_err);
        err_udf_d = (retire_valid & empty & ~flush) | (err_udf_q & ~clear_err);
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
        end else begin
            ent_valid_q <= ent_valid_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            err_ovf_q   <= err_ovf_d;
            err_udf_q   <= err_udf_d;
        end
    end

    // Entry payload; r0 is stored as non-writing so it can never hazard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_we_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                ent_dest_q[j] <= '0;
            end
        end else if (push) begin
            ent_we_q[wr_ptr_q]   <= issue_we & (issue_dest != '0);
            ent_dest_q[wr_ptr_q] <= issue_dest;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_pipe_scoreboard;

    localparam int REG_AW    = 5;
    localparam int DEPTH     = 4;
    localparam int SRC_PORTS = 2;
    localparam int BYPASS_WB = 1;
    localparam int CW        = $clog2(DEPTH + 1);

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic                        issue_valid, issue_we;
    logic [REG_AW-1:0]           issue_dest;
    logic [SRC_PORTS-1:0]        src_valid;
    logic [SRC_PORTS*REG_AW-1:0] src_addr;
    logic                        retire_valid, flush, clear_err;
    logic                        stall, full, empty, err_overflow, err_underflow;
    logic [SRC_PORTS-1:0]        src_hazard;
    logic [CW-1:0]               count;

    always #5 clk = ~clk;

    pipe_scoreboard #(
        .REG_AW   (REG_AW),
        .DEPTH    (DEPTH),
        .SRC_PORTS(SRC_PORTS),
        .BYPASS_WB(BYPASS_WB),
        .CW       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_dest   (issue_dest),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .retire_valid (retire_valid),
        .flush        (flush),
        .clear_err    (clear_err),
        .stall        (stall),
        .src_hazard   (src_hazard),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    // Reference model: in-flight instructions, oldest first.
    typedef struct {
        logic              we;
        logic [REG_AW-1:0] dest;
    } ent_t;

    ent_t q[$];
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_haz(input int i);
        logic [REG_AW-1:0] a;
        int first;
        a = src_addr[i*REG_AW +: REG_AW];
        first = ((BYPASS_WB != 0) && retire_valid) ? 1 : 0;
        if (!src_valid[i] || a == '0) return 1'b0;
        for (int k = first; k < q.size(); k++) begin
            if (q[k].we && q[k].dest == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [SRC_PORTS-1:0] m_hazv();
        logic [SRC_PORTS-1:0] h;
        h = '0;
        for (int i = 0; i < SRC_PORTS; i++) h[i] = m_haz(i);
        return h;
    endfunction

    function automatic logic m_stall();
        return (|m_hazv()) || (q.size() == DEPTH && !retire_valid);
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic was_full, was_empty, st;
        ent_t e;
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        st        = m_stall();
        if (flush) begin
            q.delete();
        end else begin
            if (retire_valid && !was_empty) void'(q.pop_front());
            if (issue_valid && !st) begin
                e.we   = issue_we && (issue_dest != '0);
                e.dest = issue_dest;
                q.push_back(e);
            end
        end
        m_ovf = (issue_valid && was_full && !retire_valid && !flush) || (m_ovf && !clear_err);
        m_udf = (retire_valid && was_empty && !flush) || (m_udf && !clear_err);
    endtask

    // Compare every output against the model mid-cycle, once inputs are settled.
    always @(negedge clk) begin
        if (!reset) begin
            check("src_hazard", 32'(src_hazard), 32'(m_hazv()));
            check("stall", 32'(stall), 32'(m_stall()));
            check("count", 32'(count), 32'(q.size()));
            check("full", 32'(full), 32'(q.size() == DEPTH));
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("err_overflow", 32'(err_overflow), 32'(m_ovf));
            check("err_underflow", 32'(err_underflow), 32'(m_udf));
        end
    end

    task automatic idle();
        issue_valid  = 1'b0;
        issue_we     = 1'b0;
        issue_dest   = '0;
        src_valid    = '0;
        src_addr     = '0;
        retire_valid = 1'b0;
        flush        = 1'b0;
        clear_err    = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue(input logic [REG_AW-1:0] d, input logic ret);
        idle();
        issue_valid  = 1'b1;
        issue_we     = 1'b1;
        issue_dest   = d;
        retire_valid = ret;
        cycle();
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_haz", 32'(src_hazard), 0);
        check("rst_errs", 32'({err_overflow, err_underflow}), 0);

        // RAW on r5, then bypass clears it during the retire cycle.
        issue(5'd5, 1'b0);
        idle();
        src_valid = 2'b01;
        src_addr  = {5'd0, 5'd5};
        #1;
        check("raw_haz", 32'(src_hazard), 32'b01);
        check("raw_stall", 32'(stall), 1);
        check("raw_count", 32'(count), 1);
        retire_valid = 1'b1;
        #1;
        check("bypass_stall", 32'(stall), 0);
        cycle();

        // r0 never hazards.
        issue(5'd0, 1'b0);
        idle();
        src_valid = 2'b01;
        src_addr  = '0;
        #1;
        check("r0_haz", 32'(src_hazard), 0);
        check("r0_count", 32'(count), 1);
        check("r0_empty", 32'(empty), 0);
        retire_valid = 1'b1;
        cycle();

        // Fill, then issue+retire while full, then overflow.
        for (int k = 1; k <= DEPTH; k++) issue(REG_AW'(k), 1'b0);
        idle();
        #1;
        check("fill_full", 32'(full), 1);
        check("fill_stall", 32'(stall), 1);
        check("fill_count", 32'(count), DEPTH);
        issue_valid  = 1'b1;
        issue_we     = 1'b1;
        issue_dest   = 5'd6;
        retire_valid = 1'b1;
        #1;
        check("full_swap_stall", 32'(stall), 0);
        cycle();
        idle();
        #1;
        check("swap_count", 32'(count), DEPTH);
        check("swap_ovf", 32'(err_overflow), 0);
        issue_valid = 1'b1;
        issue_dest  = 5'd7;
        cycle();
        idle();
        #1;
        check("ovf_set", 32'(err_overflow), 1);
        check("ovf_count", 32'(count), DEPTH);

        // Drain, underflow, clear.
        retire_valid = 1'b1;
        repeat (DEPTH + 1) cycle();
        idle();
        #1;
        check("udf_set", 32'(err_underflow), 1);
        clear_err = 1'b1;
        cycle();
        idle();
        #1;
        check("clr_errs", 32'({err_overflow, err_underflow}), 0);

        // Flush with simultaneous issue/retire.
        issue(5'd7, 1'b0);
        issue(5'd8, 1'b0);
        issue(5'd9, 1'b0);
        idle();
        #1;
        check("pre_flush_count", 32'(count), 3);
        issue_valid  = 1'b1;
        issue_we     = 1'b1;
        issue_dest   = 5'd10;
        retire_valid = 1'b1;
        flush        = 1'b1;
        cycle();
        idle();
        src_valid = 2'b01;
        src_addr  = {5'd0, 5'd7};
        #1;
        check("flush_count", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_errs", 32'({err_overflow, err_underflow}), 0);
        check("flush_haz", 32'(src_hazard), 0);

        // Wrap-around: keep two in flight while issuing 1..10, probe between issues.
        for (int k = 1; k <= 10; k++) begin
            issue(REG_AW'(k), k > 2);
            idle();
            src_valid = 2'b11;
            src_addr  = {REG_AW'($urandom_range(1, 10)), REG_AW'($urandom_range(1, 10))};
            cycle();
        end
        idle();
        src_valid = 2'b11;
        src_addr  = {5'd8, 5'd10};
        #1;
        check("wrap_haz", 32'(src_hazard), 32'b01);
        check("wrap_count", 32'(count), 2);

        // Async reset mid-cycle.
        src_addr = {5'd9, 5'd10};
        #1;
        check("pre_rst_stall", 32'(stall), 1);
        reset = 1'b1;
        #1;
        check("async_count", 32'(count), 0);
        check("async_stall", 32'(stall), 0);
        check("async_empty", 32'(empty), 1);
        model_step();
        cycle();
        reset = 1'b0;
        idle();

        // Randomized traffic.
        repeat (800) begin
            issue_valid  = 1'($urandom_range(0, 1));
            issue_we     = ($urandom_range(0, 3) != 0);
            issue_dest   = REG_AW'($urandom_range(0, 7));
            src_valid    = SRC_PORTS'($urandom);
            for (int i = 0; i < SRC_PORTS; i++) begin
                src_addr[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
            end
            retire_valid = ($urandom_range(0, 9) < 4);
            flush        = ($urandom_range(0, 39) == 0);
            clear_err    = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
